// File: rtl/btn_debounce.sv
// Button debouncer: four-state qualifier that turns a synchronized, bouncing level into a
// clean level plus one-cycle press/release pulses. Optional long-hold pulse under LONG_PRESS_EN.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LONG_CYCLES     = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic stable,
    output logic press,
    output logic release_pulse,
    output logic long_press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW:0]   DB_LAST  = (CW + 1)'(DEBOUNCE_CYCLES);
    localparam logic [CW:0]   CNT_INC  = {{CW{1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CNT_INC[CW-1:0];

    typedef enum logic [1:0] {
        ST_LOW     = 2'd0,
        ST_WAIT_HI = 2'd1,
        ST_HIGH    = 2'd2,
        ST_WAIT_LO = 2'd3
    } state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [CW:0]   cnt_inc_s;
    logic          stable_r, stable_s;
    logic          press_r, press_s;
    logic          release_r, release_s;

    // One extra bit so the qualification compare can never wrap.
    assign cnt_inc_s = {1'b0, cnt_r} + CNT_INC;

    // State, bounce counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_LOW;
            cnt_r     <= CNT_ZERO;
            stable_r  <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            stable_r  <= stable_s;
            press_r   <= press_s;
            release_r <= release_s;
        end
    end

    // Next-state and bounce counter.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_LOW: begin
                if (in) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_s = ST_HIGH;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        state_s = ST_WAIT_HI;
                        cnt_s   = CNT_ONE;
                    end
                end else begin
                    state_s = ST_LOW;
                    cnt_s   = CNT_ZERO;
                end
            end
            ST_WAIT_HI: begin
                if (!in) begin
                    state_s = ST_LOW;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_inc_s == DB_LAST) begin
                    state_s = ST_HIGH;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = ST_WAIT_HI;
                    cnt_s   = cnt_inc_s[CW-1:0];
                end
            end
            ST_HIGH: begin
                if (!in) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_s = ST_LOW;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        state_s = ST_WAIT_LO;
                        cnt_s   = CNT_ONE;
                    end
                end else begin
                    state_s = ST_HIGH;
                    cnt_s   = CNT_ZERO;
                end
            end
            ST_WAIT_LO: begin
                if (in) begin
                    state_s = ST_HIGH;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_inc_s == DB_LAST) begin
                    state_s = ST_LOW;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = ST_WAIT_LO;
                    cnt_s   = cnt_inc_s[CW-1:0];
                end
            end
            default: begin
                state_s = ST_LOW;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Output decode: pulses only on qualified transitions, never on a bounce back.
    always_comb begin
        stable_s  = (state_s == ST_HIGH) || (state_s == ST_WAIT_LO);
        press_s   = (state_s == ST_HIGH) && ((state_r == ST_WAIT_HI) || (state_r == ST_LOW));
        release_s = (state_s == ST_LOW) && ((state_r == ST_WAIT_LO) || (state_r == ST_HIGH));
    end

    assign stable        = stable_r;
    assign press         = press_r;
    assign release_pulse = release_r;

`ifdef LONG_PRESS_EN
    localparam int LW = $clog2(LONG_CYCLES + 1);
    localparam logic [LW-1:0] HOLD_MAX  = LW'(LONG_CYCLES);
    localparam logic [LW-1:0] HOLD_LAST = LW'(LONG_CYCLES - 1);
    localparam logic [LW-1:0] HOLD_ZERO = {LW{1'b0}};
    localparam logic [LW-1:0] HOLD_ONE  = {{(LW - 1){1'b0}}, 1'b1};

    logic [LW-1:0] hold_r, hold_s;
    logic          long_r, long_s;
    logic          holding_s;

    // Hold counter saturates at LONG_CYCLES so the long pulse fires once per press.
    always_comb begin
        holding_s = (state_r == ST_HIGH) || (state_r == ST_WAIT_LO);
        long_s    = holding_s && (hold_r == HOLD_LAST);
        if (press_s || (state_s == ST_LOW)) begin
            hold_s = HOLD_ZERO;
        end else if (holding_s && (hold_r != HOLD_MAX)) begin
            hold_s = hold_r + HOLD_ONE;
        end else begin
            hold_s = hold_r;
        end
    end

    // Hold counter and registered long-press pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_r <= HOLD_ZERO;
            long_r <= 1'b0;
        end else begin
            hold_r <= hold_s;
            long_r <= long_s;
        end
    end

    assign long_press = long_r;
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce: stimulus queues expected pulses (kind + edge index),
// a monitor pops and compares whenever a pulse appears, and checks outputs during reset.
`timescale 1ns/100ps
module tb_btn_debounce;
    localparam logic [2:0] K_PRESS = 3'b001;
    localparam logic [2:0] K_REL   = 3'b010;
    localparam logic [2:0] K_LONG  = 3'b100;

    typedef struct {
        logic [2:0] kind;
        int         cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    logic btn;
    logic stable, press, release_pulse, long_press;
    logic done = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    bit   final_done = 1'b0;
    ev_t  q[$];

    btn_debounce #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in(btn),
        .stable(stable),
        .press(press),
        .release_pulse(release_pulse),
        .long_press(long_press)
    );

    always #2 clk = ~clk;

    // Rising-edge index; a sample taken just after edge k sees cyc == k.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_ev(input logic [2:0] kind, input int at);
        ev_t e;
        e.kind = kind;
        e.cyc  = at;
        q.push_back(e);
    endtask

    // Drive v for n cycles; first = index of the edge that samples the first value.
    task automatic put(input logic v, input int n, output int first);
        first = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) first = cyc + 1;
            btn = v;
        end
    endtask

    // Monitor: reset-state checks and scoreboard comparison of every pulse.
    always @(posedge clk or negedge rst_n) begin
        ev_t        e;
        logic [2:0] act;
        #1;
        if (!rst_n) begin
            tests++;
            if ({stable, press, release_pulse, long_press} !== 4'b0000) begin
                fails++;
                $display("FAIL reset_outputs: got %b required 0000 at t=%0t",
                         {stable, press, release_pulse, long_press}, $time);
            end
        end else begin
            act = {long_press, release_pulse, press};
            if (act != 3'b000) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_pulse: got kind %b at edge %0d, none required", act, cyc);
                end else begin
                    e = q.pop_front();
                    if (act !== e.kind || cyc != e.cyc) begin
                        fails++;
                        $display("FAIL pulse: got kind %b at edge %0d, required kind %b at edge %0d",
                                 act, cyc, e.kind, e.cyc);
                    end
                    tests++;
                    if (stable !== (e.kind != K_REL)) begin
                        fails++;
                        $display("FAIL stable_at_pulse: got %b required %b at edge %0d",
                                 stable, (e.kind != K_REL), cyc);
                    end
                end
            end
            if (done && !final_done) begin
                final_done = 1'b1;
                tests++;
                if (q.size() != 0) begin
                    fails++;
                    $display("FAIL missing_pulses: %0d still pending, required 0 (next kind %b at edge %0d)",
                             q.size(), q[0].kind, q[0].cyc);
                end
            end
        end
    end

    initial begin
        int f, g, h, a, b, c, d, r, s, x;
        btn   = 1'b0;
        rst_n = 1'b0;
        // Reset with the input toggling.
        repeat (13) @(negedge clk) btn = ~btn;
        @(negedge clk);
        btn   = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Clean press held 20 cycles.
        put(1'b1, 1, f);
        expect_ev(K_PRESS, f + 3);
`ifdef LONG_PRESS_EN
        expect_ev(K_LONG, f + 19);
`endif
        put(1'b1, 19, x);

        // Clean release.
        put(1'b0, 1, g);
        expect_ev(K_REL, g + 3);
        put(1'b0, 7, x);

        // Press again, then release with a one-cycle glitch at the second edge.
        put(1'b1, 1, h);
        expect_ev(K_PRESS, h + 3);
        put(1'b1, 5, x);
        put(1'b0, 1, a);
        expect_ev(K_REL, a + 5);
        put(1'b1, 1, x);
        put(1'b0, 8, x);

        // Bouncy press: 1x3, 0, 1x3, 0, then held.
        put(1'b1, 1, b);
        expect_ev(K_PRESS, b + 11);
        put(1'b1, 2, x);
        put(1'b0, 1, x);
        put(1'b1, 3, x);
        put(1'b0, 1, x);
        put(1'b1, 8, x);
        put(1'b0, 1, c);
        expect_ev(K_REL, c + 3);
        put(1'b0, 5, x);

        // Reset mid-qualification aborts it; input held high through reset.
        put(1'b1, 2, d);
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        expect_ev(K_PRESS, d + 6);
        put(1'b1, 6, x);
        put(1'b0, 1, r);
        expect_ev(K_REL, r + 3);
        put(1'b0, 5, x);

        // Long hold, then asynchronous reset while stable is high.
        put(1'b1, 1, s);
        expect_ev(K_PRESS, s + 3);
`ifdef LONG_PRESS_EN
        expect_ev(K_LONG, s + 19);
`endif
        put(1'b1, 29, x);
        @(negedge clk) rst_n = 1'b0;
        repeat (2) @(negedge clk);
        btn   = 1'b0;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        done = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
